// File: rtl/dbg_view_mux_pkg.sv
// Shared definitions for the dbg_view_mux debug-view slice.
//   view_state_e        : LIVE (display tracks probes) / HOLD (display frozen)
//   DEFAULT_SCROLL_DIV  : default clock cycles per auto-scroll channel step
//   clog2()             : index width helper, never returns less than 1
package dbg_view_pkg;

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } view_state_e;

  localparam int unsigned DEFAULT_SCROLL_DIV = 50000000;

  // Width needed to index n items; a 2-entry set still gets one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/dbg_view_mux_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
// Only built with DBG_VIEW_STATS_EN defined, the only configuration that uses it.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset, count -> 0
//   inc    in  add one this cycle (ignored once saturated)
//   clr    in  zero the count; wins over inc
//   count  out registered count
`ifdef DBG_VIEW_STATS_EN
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/dbg_view_mux.sv
// dbg_view_mux: debug-view selector between the core probes and board display.
// Picks one of NUM_CH probe words (manual index or timed auto-scroll), registers
// it together with the bus address, and can freeze the display with 'hold'.
// Optional macro DBG_VIEW_STATS_EN adds saturating cache hit/miss counters with a
// clear path (hold & acc_stb & !hit_in); without it hit_cnt/miss_cnt read 0.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   ch_data               packed probes, channel k at [k*DATA_W +: DATA_W]
//   addr_in               current memory address
//   sel_man               manual channel index (clamped to NUM_CH-1)
//   auto_en               1 = auto-scroll, 0 = manual select
//   hold                  level, freeze display/channel/divider while high
//   acc_stb, hit_in       cache access strobe and hit qualifier
//   disp_data, disp_addr  registered displayed word and address
//   cur_ch                channel currently shown
//   hit_cnt, miss_cnt     saturating access counters
//   frozen                1 while in HOLD
module dbg_view_mux
  import dbg_view_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned SCROLL_DIV = DEFAULT_SCROLL_DIV,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH*DATA_W-1:0]    ch_data,
  input  logic [ADDR_W-1:0]           addr_in,
  input  logic [clog2(NUM_CH)-1:0]    sel_man,
  input  logic                        auto_en,
  input  logic                        hold,
  input  logic                        acc_stb,
  input  logic                        hit_in,
  output logic [DATA_W-1:0]           disp_data,
  output logic [ADDR_W-1:0]           disp_addr,
  output logic [clog2(NUM_CH)-1:0]    cur_ch,
  output logic [CNT_W-1:0]            hit_cnt,
  output logic [CNT_W-1:0]            miss_cnt,
  output logic                        frozen
);

  localparam int unsigned SEL_W = clog2(NUM_CH);
  localparam int unsigned DIV_W = clog2(SCROLL_DIV);

  view_state_e       state_q, state_d;
  logic              frozen_q, frozen_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    div_d       = div_q;
    disp_data_d = disp_data_q;
    disp_addr_d = disp_addr_q;

    case (state_q)
      LIVE:    if (hold)  state_d = HOLD;
      HOLD:    if (!hold) state_d = LIVE;
      default: state_d = LIVE;
    endcase
    frozen_d = (state_d == HOLD);

    // The edge that enters HOLD still captures, and the edge that leaves it
    // already captures, so only HOLD with hold still high keeps the display.
    if (!((state_q == HOLD) && hold)) begin
      disp_data_d = ch_data[32'(cur_ch_q)*DATA_W +: DATA_W];
      disp_addr_d = addr_in;
    end

    // The divider sits at 0 whenever manual mode is selected, so entering
    // auto mode always starts a full period from the current channel.
    // The hold input (not the state) gates stepping, so hold beats terminal count.
    if (!auto_en) begin
      div_d = '0;
      if (!hold) begin
        if (32'(sel_man) > NUM_CH - 1) begin
          cur_ch_d = SEL_W'(NUM_CH - 1);
        end else begin
          cur_ch_d = sel_man;
        end
      end
    end else if (!hold) begin
      if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
        div_d    = '0;
        cur_ch_d = (cur_ch_q == SEL_W'(NUM_CH - 1)) ? '0 : cur_ch_q + SEL_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LIVE;
      frozen_q    <= 1'b0;
      cur_ch_q    <= '0;
      div_q       <= '0;
      disp_data_q <= '0;
      disp_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      frozen_q    <= frozen_d;
      cur_ch_q    <= cur_ch_d;
      div_q       <= div_d;
      disp_data_q <= disp_data_d;
      disp_addr_q <= disp_addr_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_addr = disp_addr_q;
  assign cur_ch    = cur_ch_q;
  assign frozen    = frozen_q;

`ifdef DBG_VIEW_STATS_EN
  logic hit_inc, miss_inc, cnt_clr;

  always_comb begin
    hit_inc  = acc_stb & hit_in;
    miss_inc = acc_stb & ~hit_in;
    cnt_clr  = hold & acc_stb & ~hit_in;
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit_inc),
    .clr   (cnt_clr),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (miss_inc),
    .clr   (cnt_clr),
    .count (miss_cnt)
  );
`else
  logic unused_stats;

  always_comb begin
    unused_stats = ^{acc_stb, hit_in};
  end

  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dbg_view_mux.sv
module tb_dbg_view_mux;

  localparam int unsigned NUM_CH     = 5;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned SCROLL_DIV = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SEL_W      = 3;
  localparam int          CNT_MAX    = 15;

  logic                     clock;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [ADDR_W-1:0]        addr_in;
  logic [SEL_W-1:0]         sel_man;
  logic                     auto_en;
  logic                     hold;
  logic                     acc_stb;
  logic                     hit_in;
  logic [DATA_W-1:0]        disp_data;
  logic [ADDR_W-1:0]        disp_addr;
  logic [SEL_W-1:0]         cur_ch;
  logic [CNT_W-1:0]         hit_cnt;
  logic [CNT_W-1:0]         miss_cnt;
  logic                     frozen;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference view of the block, kept as plain integers.
  int m_ch, m_div, m_frozen, m_data, m_addr, m_hit, m_miss;

  dbg_view_mux #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .SCROLL_DIV (SCROLL_DIV),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .ch_data   (ch_data),
    .addr_in   (addr_in),
    .sel_man   (sel_man),
    .auto_en   (auto_en),
    .hold      (hold),
    .acc_stb   (acc_stb),
    .hit_in    (hit_in),
    .disp_data (disp_data),
    .disp_addr (disp_addr),
    .cur_ch    (cur_ch),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .frozen    (frozen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Applies the rules for one clock edge to the reference, using pre-edge inputs.
  task automatic model_edge();
    if (reset) begin
      m_ch = 0; m_div = 0; m_frozen = 0; m_data = 0; m_addr = 0; m_hit = 0; m_miss = 0;
    end else begin
      if (!(m_frozen == 1 && hold)) begin
        m_data = int'(ch_data[m_ch*DATA_W +: DATA_W]);
        m_addr = int'(addr_in);
      end
      if (!auto_en) begin
        m_div = 0;
        if (!hold) m_ch = (int'(sel_man) > NUM_CH - 1) ? NUM_CH - 1 : int'(sel_man);
      end else if (!hold) begin
        m_div = m_div + 1;
        if (m_div == SCROLL_DIV) begin
          m_div = 0;
          m_ch  = (m_ch + 1) % NUM_CH;
        end
      end
`ifdef DBG_VIEW_STATS_EN
      if (acc_stb) begin
        if (hold && !hit_in) begin
          m_hit = 0; m_miss = 0;
        end else if (hit_in) begin
          m_hit = (m_hit < CNT_MAX) ? m_hit + 1 : CNT_MAX;
        end else begin
          m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : CNT_MAX;
        end
      end
`endif
      m_frozen = hold ? 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("disp_data", 32'(disp_data), 32'(m_data));
    chk("disp_addr", 32'(disp_addr), 32'(m_addr));
    chk("cur_ch",    32'(cur_ch),    32'(m_ch));
    chk("frozen",    32'(frozen),    32'(m_frozen));
    chk("hit_cnt",   32'(hit_cnt),   32'(m_hit));
    chk("miss_cnt",  32'(miss_cnt),  32'(m_miss));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; ch_data = '0; addr_in = '0; sel_man = '0;
    auto_en = 1'b0; hold = 1'b0; acc_stb = 1'b0; hit_in = 1'b0;
    m_ch = 0; m_div = 0; m_frozen = 0; m_data = 0; m_addr = 0; m_hit = 0; m_miss = 0;

    // Reset state
    steps(2);
    chk("rst_disp_data", 32'(disp_data), 32'h0);
    chk("rst_cur_ch",    32'(cur_ch),    32'h0);
    chk("rst_frozen",    32'(frozen),    32'h0);

    // Manual select: cur_ch after one edge, data after two
    reset = 1'b0;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = 16'(32'h1111 * (k + 1));
    addr_in = 8'h5A;
    sel_man = 3'd2;
    step();
    chk("man_cur_ch_1edge", 32'(cur_ch), 32'd2);
    step();
    chk("man_data_2edge", 32'(disp_data), 32'h3333);
    chk("man_addr", 32'(disp_addr), 32'h5A);

    // Out-of-range index clamps to the last channel
    sel_man = 3'd7;
    step();
    chk("clamp_cur_ch", 32'(cur_ch), 32'd4);
    step();
    chk("clamp_data", 32'(disp_data), 32'h5555);

    // Hold freezes display and channel, release shows new data next edge
    sel_man = 3'd1;
    steps(2);
    chk("pre_hold_data", 32'(disp_data), 32'h2222);
    hold = 1'b1;
    step();
    chk("hold_enter_frozen", 32'(frozen), 32'd1);
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = 16'(32'hA000 + k);
    addr_in = 8'hC3;
    sel_man = 3'd3;
    steps(3);
    chk("hold_data_kept", 32'(disp_data), 32'h2222);
    chk("hold_addr_kept", 32'(disp_addr), 32'h5A);
    chk("hold_cur_ch_kept", 32'(cur_ch), 32'd1);
    hold = 1'b0;
    step();
    chk("release_data", 32'(disp_data), 32'hA001);
    chk("release_frozen", 32'(frozen), 32'd0);
    step();
    chk("release_new_ch_data", 32'(disp_data), 32'hA003);

    // Auto-scroll from the last channel wraps to 0, then steps to 1
    sel_man = 3'd4;
    step();
    auto_en = 1'b1;
    steps(3);
    chk("auto_before_tc", 32'(cur_ch), 32'd4);
    step();
    chk("auto_wrap_4", 32'(cur_ch), 32'd0);
    steps(4);
    chk("auto_step_8", 32'(cur_ch), 32'd1);

    // Hold coinciding with terminal count blocks the step
    steps(3);
    hold = 1'b1;
    step();
    chk("hold_vs_tc_ch", 32'(cur_ch), 32'd1);
    hold = 1'b0;
    step();
    chk("tc_after_release", 32'(cur_ch), 32'd2);

    // Reset during hold mid-scroll
    hold = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rst_hold_frozen", 32'(frozen), 32'd0);
    chk("rst_hold_cur_ch", 32'(cur_ch), 32'd0);
    chk("rst_hold_data", 32'(disp_data), 32'd0);
    reset = 1'b0; hold = 1'b0;
    steps(3);
    chk("rst_full_period_hold", 32'(cur_ch), 32'd0);
    step();
    chk("rst_full_period_step", 32'(cur_ch), 32'd1);

    // Counters: saturation, single miss, clear
    auto_en = 1'b0; sel_man = 3'd0;
    acc_stb = 1'b1; hit_in = 1'b1;
    steps(20);
`ifdef DBG_VIEW_STATS_EN
    chk("hit_saturated", 32'(hit_cnt), 32'hF);
`else
    chk("hit_disabled", 32'(hit_cnt), 32'h0);
`endif
    chk("miss_after_hits", 32'(miss_cnt), 32'h0);
    hit_in = 1'b0;
    step();
`ifdef DBG_VIEW_STATS_EN
    chk("miss_one", 32'(miss_cnt), 32'h1);
`else
    chk("miss_disabled", 32'(miss_cnt), 32'h0);
`endif
    hold = 1'b1;
    step();
    chk("clr_hit", 32'(hit_cnt), 32'h0);
    chk("clr_miss", 32'(miss_cnt), 32'h0);
    acc_stb = 1'b0; hold = 1'b0;
    step();

    // Randomized traffic against the reference
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0)  hold = ~hold;
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      sel_man = 3'($urandom_range(0, 7));
      addr_in = 8'($urandom);
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 3) == 0) ch_data[k*DATA_W +: DATA_W] = 16'($urandom);
      end
      acc_stb = ($urandom_range(0, 1) == 1);
      hit_in  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dbg_view_mux.md
Name: dbg_view_mux

Overview:
- Parametrised debug-view block between the processor/cache core and the board 7-segment/LED outputs.
- Selects one of NUM_CH probe words, either manually or by timed auto-scroll.
- Registers the selected word and the bus address for display, with a freeze (hold) function.
- Counts cache hit/miss events so they can be shown on the board.

Parameters:
- NUM_CH, 4, number of probe channels (2..16).
- DATA_W, 16, probe and display word width.
- ADDR_W, 8, displayed address width.
- SCROLL_DIV, 50000000, clock cycles per channel step in auto mode (>=2).
- CNT_W, 16, hit/miss counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ch_data  in  NUM_CH*DATA_W  packed probes; channel k = ch_data[k*DATA_W +: DATA_W].
- addr_in  in  ADDR_W  current memory address.
- sel_man  in  $clog2(NUM_CH)  manual channel index.
- auto_en  in  1  1 = auto-scroll, 0 = manual.
- hold  in  1  level; freeze displayed values while high.
- acc_stb  in  1  one-cycle pulse per cache access.
- hit_in  in  1  qualifies acc_stb; 1 = hit.
- disp_data  out  DATA_W  registered displayed word.
- disp_addr  out  ADDR_W  registered displayed address.
- cur_ch  out  $clog2(NUM_CH)  channel currently shown.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.
- frozen  out  1  1 while in HOLD state.

Behaviour:
Reset (synchronous, active-high):
- All outputs go to 0.
- Scroll divider goes to 0.
- FSM goes to LIVE.

FSM states and transitions:
- LIVE -> HOLD when hold=1.
- HOLD -> LIVE when hold=0.
- frozen = (state==HOLD), registered.

Channel select:
- Manual (auto_en=0): cur_ch <= sel_man on the next edge.
- If sel_man >= NUM_CH, cur_ch <= NUM_CH-1.

Auto-scroll (auto_en=1):
- Divider counts 0..SCROLL_DIV-1.
- At terminal count: cur_ch <= (cur_ch==NUM_CH-1) ? 0 : cur_ch+1, and the divider wraps to 0.
- Switching auto_en 0->1: the divider restarts at 0 and scrolling starts from the current cur_ch.
- Switching auto_en 1->0: cur_ch takes sel_man on the next edge.

Display registers:
- In LIVE: disp_data <= ch_data[cur_ch] and disp_addr <= addr_in every cycle.
- Latency: 1 cycle from probe change; 2 cycles from a sel_man change (cur_ch, then data).
- In HOLD: disp_data, disp_addr and cur_ch are held, and the scroll divider is held.
- Counters keep counting while in HOLD.
- The hold sample taken on the entering edge is the last LIVE update; values present at that edge are captured.

Counters:
- On acc_stb=1: hit_cnt += hit_in, miss_cnt += ~hit_in.
- Counters saturate at all-ones; no wrap.
- hit_in is ignored when acc_stb=0.

Simultaneous events:
- reset has priority over everything.
- hold and the scroll terminal count in the same cycle: hold wins, the divider does not advance, cur_ch is unchanged.
- Reset asserted mid-scroll or mid-hold returns to LIVE, channel 0, divider 0.

Optional Feature:
Macro DBG_VIEW_STATS_EN.
- Defined: hit/miss counters as above, plus a clear path — both counters are zeroed when hold and acc_stb are high in the same cycle with hit_in=0.
- Undefined: no counter logic; hit_cnt and miss_cnt tied to 0; acc_stb and hit_in unused.

Decomposition:
- Shared package dbg_view_pkg holds:
  - state encoding: LIVE=1'b0, HOLD=1'b1;
  - default SCROLL_DIV constant;
  - function clog2 for the index width.
- One sub-module is natural: sat_counter (params W; ports clock, reset, inc, clr, count), instantiated twice for hit and miss.

Test Plan:
- Manual select, NUM_CH=4, DATA_W=16: probes 16'h1111/2222/3333/4444, sel_man=2 -> cur_ch=2 after 1 edge, disp_data=16'h3333 after 2 edges.
- Auto-scroll, SCROLL_DIV=4, auto_en=1 from cur_ch=3 -> cur_ch 0 after 4 cycles, then 1 after 8 cycles.
- Hold: assert hold while disp_data=16'h2222, then change all probes -> disp_data stays 16'h2222 and frozen=1. Release -> new value 1 cycle later.
- Counters, CNT_W=4, stats enabled: 20 strobes with hit_in=1 -> hit_cnt saturates at 4'hF, miss_cnt=0. One strobe with hit_in=0 -> miss_cnt=1.
- Counter clear, stats enabled: hold=1, acc_stb=1, hit_in=0 -> both counters 0 next cycle. Same build without the macro -> both counters constant 0 throughout.
- Reset mid-scroll: assert reset with cur_ch=2 in HOLD -> next edge all outputs 0, frozen=0. After reset, scrolling resumes from channel 0 with the full SCROLL_DIV period.
